// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for an N-digit common-segment 7-segment display.
// Latency: outputs are registered, one cycle behind (scan_idx, cnt).
// No backpressure: free-running slot timer gated by en; a frame snapshot isolates input changes.
module seg_scan_driver #(
  parameter int N_DIGITS = 8,
  parameter int SLOT_CYC = 50000,
  parameter int DEAD_CYC = 2,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int CW = $clog2(SLOT_CYC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  blank_lz,
  output logic [3:0]            bcd_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   dig_sel_n,
  output logic [IW-1:0]         scan_idx
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SCAN  = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] dig_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic                  blz_q;
  logic                  frame_start;

  logic [N_DIGITS-1:0]   sel_q, sel_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  dpo_q, dpo_d;

  logic [N_DIGITS-1:0]   lz_blank;
  logic                  allz;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;

  // Slot timer / digit index sequencing and frame-start detection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_start = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      idx_d = '0;
      if (en) begin
        state_d     = ST_SCAN;
        frame_start = 1'b1;
      end
    end else if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d       = '0;
        frame_start = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Leading-zero blanking: a digit blanks when it and every more significant digit are zero
  always_comb begin
    lz_blank = '0;
    allz     = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      allz = allz & (dig_q[4*i +: 4] == 4'h0);
      if (i != 0) lz_blank[i] = blz_q & allz;
    end
  end

  // Select the active digit's snapshot fields and build the next registered outputs
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_d     = '1;
    bcd_d     = 4'hF;
    dpo_d     = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = dig_q[4*i +: 4];
        cur_dp    = dp_q[i];
        cur_blank = lz_blank[i];
      end
    end
    // Going dark on the same edge en is seen low keeps dig_sel_n clean across en drops
    if (state_q == ST_SCAN && en && cnt_q >= CNT_DEAD) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_q == IW'(i)) sel_d[i] = 1'b0;
      end
      bcd_d = cur_blank ? 4'hF : cur_nib;
      dpo_d = cur_dp;
    end
  end

  // State, snapshot and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      dp_q    <= '0;
      blz_q   <= 1'b0;
      sel_q   <= '1;
      bcd_q   <= 4'hF;
      dpo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (frame_start) begin
        dig_q <= digits;
        dp_q  <= dp_mask;
        blz_q <= blank_lz;
      end
      sel_q   <= sel_d;
      bcd_q   <= bcd_d;
      dpo_q   <= dpo_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign dp_out    = dpo_q;
  assign dig_sel_n = sel_q;
  assign scan_idx  = idx_q;

endmodule
